// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detection_unit
//  Description : Stalls PC and IF/ID on load-use and branch-operand hazards
//                that forwarding cannot cover. Inserts ID/EX bubbles, flushes
//                IF/ID on taken branches and jumps, and keeps saturating
//                stall and flush statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detection_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [REG_W-1:0] IDEX_WR,
  input  logic             EXMEM_MemRead,
  input  logic [REG_W-1:0] EXMEM_WR,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic       idex_match;
  logic       exmem_match;
  logic       need_two;
  logic       need_one;
  logic [1:0] n_req;
  logic       stall;
  logic       stall_eff;
  logic       flush_eff;

  // Source-operand match against the EX and MEM destinations; $0 never matches
  // and a destination equal to both Rs and Rt yields a single match.
  always_comb begin
    idex_match  = (IDEX_WR != '0) &&
                  ((IDEX_WR == IFID_Rs) || (ID_UsesRt && (IDEX_WR == IFID_Rt)));
    exmem_match = (EXMEM_WR != '0) &&
                  ((EXMEM_WR == IFID_Rs) || (ID_UsesRt && (EXMEM_WR == IFID_Rt)));
  end

  // Hazard classification; the required stall count is the largest that applies.
  always_comb begin
    need_two = ID_Branch && IDEX_MemRead && idex_match;
    need_one = (!ID_Branch && IDEX_MemRead && idex_match) ||
               (ID_Branch && IDEX_RegWrite && !IDEX_MemRead && idex_match) ||
               (ID_Branch && EXMEM_MemRead && exmem_match);
    if (need_two) begin
      n_req = 2'd2;
    end else if (need_one) begin
      n_req = 2'd1;
    end else begin
      n_req = 2'd0;
    end
  end

  // Next-state logic: a two-cycle hazard parks in STALL for one extra cycle,
  // during which detection is masked.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      RUN: begin
        if (n_req != 2'd0) begin
          stall = 1'b1;
          if (n_req == 2'd2) begin
            state_d = STALL;
            cnt_d   = 2'd1;
          end
        end
      end
      STALL: begin
        stall   = 1'b1;
        state_d = RUN;
        cnt_d   = 2'd0;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Pipeline control outputs; a low reset forces the pass-through values
  // regardless of whatever hazard the inputs present.
  always_comb begin
    stall_eff   = stall && reset;
    flush_eff   = reset && !stall && (ID_Jump || (ID_Branch && ID_BranchTaken));
    PCWrite     = !stall_eff;
    IFID_Write  = !stall_eff;
    IDEX_Bubble = stall_eff;
    IFID_Flush  = flush_eff;
  end

  // Saturating statistics: hold at all-ones instead of wrapping.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_eff && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if (flush_eff && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // State and statistics registers; reset abandons any pending stall cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      cnt_q          <= 2'd0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_detection_unit
//  Description : Directed self-checking bench for hazard_detection_unit,
//                with a second narrow-counter instance for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_detection_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int SCNT_W = 4;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] IFID_Rs, IFID_Rt, IDEX_WR, EXMEM_WR;
  logic             ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic             IDEX_MemRead, IDEX_RegWrite, EXMEM_MemRead;
  logic             PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic             s_PCWrite, s_IFID_Write, s_IDEX_Bubble, s_IFID_Flush;
  logic [SCNT_W-1:0] s_stall_cycles, s_flush_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_detection_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WR(IDEX_WR),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WR(EXMEM_WR),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
    .IFID_Flush(IFID_Flush), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_detection_unit #(.REG_W(REG_W), .CNT_W(SCNT_W)) dut_small (
    .clk(clk), .reset(reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .ID_Jump(ID_Jump),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_WR(IDEX_WR),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WR(EXMEM_WR),
    .PCWrite(s_PCWrite), .IFID_Write(s_IFID_Write), .IDEX_Bubble(s_IDEX_Bubble),
    .IFID_Flush(s_IFID_Flush), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic pcw, input logic ifw,
                           input logic bub, input logic fl);
    check({tag, ".PCWrite"},     32'(PCWrite),     32'(pcw));
    check({tag, ".IFID_Write"},  32'(IFID_Write),  32'(ifw));
    check({tag, ".IDEX_Bubble"}, 32'(IDEX_Bubble), 32'(bub));
    check({tag, ".IFID_Flush"},  32'(IFID_Flush),  32'(fl));
  endtask

  task automatic check_cnt(input string tag);
    check({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_stall));
    check({tag, ".flush_count"},  32'(flush_count),  32'(exp_flush));
  endtask

  task automatic set_idle();
    IFID_Rs = '0; IFID_Rt = '0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_BranchTaken = 1'b0; ID_Jump = 1'b0;
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0; IDEX_WR = '0;
    EXMEM_MemRead = 1'b0; EXMEM_WR = '0;
  endtask

  // Advance past the next rising edge; inputs are changed just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    #2;
    check_ctl("reset", 1'b1, 1'b1, 1'b0, 1'b0);
    check_cnt("reset");
    check("reset.state", 32'(dut.state_q), 32'd0);
    step();
    reset = 1'b1;
    #1;
    check_ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);

    // Load-use on Rs: one stall cycle.
    IDEX_MemRead = 1'b1; IDEX_WR = 5'd8; IFID_Rs = 5'd8;
    #1 check_ctl("lu", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); exp_stall++;
    check("lu.state", 32'(dut.state_q), 32'd0);
    set_idle();
    #1 check_ctl("lu_after", 1'b1, 1'b1, 1'b0, 1'b0);
    check_cnt("lu_after");

    // $0 destination never stalls; Rt ignored when not a source.
    IDEX_MemRead = 1'b1; IDEX_WR = 5'd0; IFID_Rs = 5'd0;
    #1 check_ctl("zero_reg", 1'b1, 1'b1, 1'b0, 1'b0);
    IDEX_WR = 5'd7; IFID_Rs = 5'd3; IFID_Rt = 5'd7; ID_UsesRt = 1'b0;
    #1 check_ctl("rt_unused", 1'b1, 1'b1, 1'b0, 1'b0);
    // Rs and Rt both match: one hazard, one stall cycle.
    IFID_Rs = 5'd7; ID_UsesRt = 1'b1;
    #1 check_ctl("both_match", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); exp_stall++;
    set_idle();
    #1 check_cnt("both_match");

    // Load then branch: two stall cycles, RUN -> STALL -> RUN, then flush.
    ID_Branch = 1'b1; IDEX_MemRead = 1'b1; IDEX_WR = 5'd9;
    IFID_Rs = 5'd3; IFID_Rt = 5'd9; ID_UsesRt = 1'b1;
    #1 check_ctl("bl2_c0", 1'b0, 1'b0, 1'b1, 1'b0);
    check("bl2_c0.state", 32'(dut.state_q), 32'd0);
    step(); exp_stall++;
    IDEX_MemRead = 1'b0; IDEX_WR = 5'd0; EXMEM_MemRead = 1'b1; EXMEM_WR = 5'd9;
    #1 check_ctl("bl2_c1", 1'b0, 1'b0, 1'b1, 1'b0);
    check("bl2_c1.state", 32'(dut.state_q), 32'd1);
    step(); exp_stall++;
    EXMEM_MemRead = 1'b0; EXMEM_WR = 5'd0; ID_BranchTaken = 1'b1;
    #1 check_ctl("bl2_flush", 1'b1, 1'b1, 1'b0, 1'b1);
    check("bl2_flush.state", 32'(dut.state_q), 32'd0);
    step(); exp_flush++;
    set_idle();
    #1 check_ctl("bl2_done", 1'b1, 1'b1, 1'b0, 1'b0);
    check_cnt("bl2_done");

    // ALU result feeding a branch: one stall; same with $0 gives none.
    ID_Branch = 1'b1; IDEX_RegWrite = 1'b1; IDEX_WR = 5'd10; IFID_Rs = 5'd10;
    #1 check_ctl("ba", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); exp_stall++;
    check("ba.state", 32'(dut.state_q), 32'd0);
    IDEX_WR = 5'd0; IFID_Rs = 5'd0;
    #1 check_ctl("ba_zero", 1'b1, 1'b1, 1'b0, 1'b0);
    set_idle();

    // Load in MEM feeding a branch: one stall.
    ID_Branch = 1'b1; EXMEM_MemRead = 1'b1; EXMEM_WR = 5'd5; IFID_Rs = 5'd5;
    #1 check_ctl("bl1", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); exp_stall++;
    check("bl1.state", 32'(dut.state_q), 32'd0);
    set_idle();

    // Stall with a taken branch: flush held off until the stall clears.
    ID_Branch = 1'b1; ID_BranchTaken = 1'b1;
    IDEX_RegWrite = 1'b1; IDEX_WR = 5'd11; IFID_Rs = 5'd11;
    #1 check_ctl("ba_taken", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); exp_stall++;
    IDEX_RegWrite = 1'b0; IDEX_WR = 5'd0;
    #1 check_ctl("ba_taken_fl", 1'b1, 1'b1, 1'b0, 1'b1);
    step(); exp_flush++;
    set_idle();

    // Jump flushes without stalling.
    ID_Jump = 1'b1;
    #1 check_ctl("jump", 1'b1, 1'b1, 1'b0, 1'b1);
    step(); exp_flush++;
    set_idle();
    #1 check_cnt("jump_after");

    // Reset asserted in STALL: outputs forced immediately, counters cleared.
    ID_Branch = 1'b1; IDEX_MemRead = 1'b1; IDEX_WR = 5'd9;
    IFID_Rt = 5'd9; ID_UsesRt = 1'b1;
    step();
    #1 check("rst_mid.pre_state", 32'(dut.state_q), 32'd1);
    reset = 1'b0;
    #1 check_ctl("rst_mid", 1'b1, 1'b1, 1'b0, 1'b0);
    exp_stall = 0; exp_flush = 0;
    check_cnt("rst_mid");
    check("rst_mid.state", 32'(dut.state_q), 32'd0);
    step();
    set_idle();
    reset = 1'b1;
    #1 check("rst_rel.state", 32'(dut.state_q), 32'd0);
    check_ctl("rst_rel", 1'b1, 1'b1, 1'b0, 1'b0);

    // Saturation: 20 load-use stall cycles on a 4-bit counter stop at 15.
    IDEX_MemRead = 1'b1; IDEX_WR = 5'd8; IFID_Rs = 5'd8;
    for (int i = 0; i < 20; i++) begin
      step();
    end
    exp_stall = 20;
    set_idle();
    #1 check("sat.small_stall", 32'(s_stall_cycles), 32'd15);
    check("sat.small_flush", 32'(s_flush_count), 32'd0);
    check_cnt("sat.wide");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Companion to the forwarding unit in the 5-stage MIPS pipeline. The forwarding unit pushes results forward; this block holds the front end back when forwarding cannot cover a dependency.
- Sits between the IF/ID and ID/EX registers. Detects load-use hazards and branch-operand hazards (branches resolve in ID) and stalls PC and IF/ID for 1 or 2 cycles.
- Inserts bubbles into ID/EX, flushes IF/ID on a taken branch or jump, and keeps saturating stall and flush statistics.

Parameters:
- REG_W, 5, register-specifier width
- CNT_W, 16, width of the statistics counters

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low reset
- IFID_Rs  input  REG_W  Rs of the instruction in ID
- IFID_Rt  input  REG_W  Rt of the instruction in ID
- ID_UsesRt  input  1  ID instruction reads Rt as a source (R-type, beq, bne, sw)
- ID_Branch  input  1  ID instruction is beq or bne
- ID_BranchTaken  input  1  branch comparison in ID is true; valid only when operands are ready
- ID_Jump  input  1  ID instruction is j, jal or jr
- IDEX_MemRead  input  1  EX-stage instruction is a load
- IDEX_RegWrite  input  1  EX-stage instruction writes a register
- IDEX_WR  input  REG_W  EX-stage destination register
- EXMEM_MemRead  input  1  MEM-stage instruction is a load
- EXMEM_WR  input  REG_W  MEM-stage destination register
- PCWrite  output  1  1 = PC may update
- IFID_Write  output  1  1 = IF/ID may load
- IDEX_Bubble  output  1  1 = zero the control fields entering ID/EX
- IFID_Flush  output  1  1 = replace the IF/ID contents with a nop
- stall_cycles  output  CNT_W  number of stall cycles, saturating
- flush_count  output  CNT_W  number of flushes, saturating

Behaviour:
- Source match for a register X: X != 0 and (X == IFID_Rs, or (ID_UsesRt and X == IFID_Rt)).
- Hazard classification, evaluated only in state RUN. N is the number of stall cycles required.
  - LU (load-use): IDEX_MemRead and IDEX_WR matches, ID_Branch = 0 -> N = 1.
  - BL2: ID_Branch and IDEX_MemRead and IDEX_WR matches -> N = 2.
  - BA: ID_Branch and IDEX_RegWrite and not IDEX_MemRead and IDEX_WR matches -> N = 1.
  - BL1: ID_Branch and EXMEM_MemRead and EXMEM_WR matches -> N = 1.
  - If several conditions hold, N is the maximum of them.
- FSM states: RUN and STALL. Registers: state and a 2-bit cnt.
- RUN with N > 0:
  - stall = 1 in this cycle.
  - If N == 2, go to STALL with cnt = 1; otherwise stay in RUN.
- STALL:
  - stall = 1, detection is masked.
  - Next cycle: RUN, cnt = 0.
  - After returning to RUN, detection re-evaluates on the next cycle.
- Outputs, combinational from state and inputs:
  - When stall = 1: PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1.
  - Otherwise: PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0.
- Flush:
  - IFID_Flush = 1 when stall = 0 and (ID_Jump, or (ID_Branch and ID_BranchTaken)).
  - When stall = 1, IFID_Flush is forced to 0, because the branch is unresolved or the ID instruction is held.
  - The flush lasts exactly 1 cycle per resolved instruction.
  - PCWrite stays 1 during a flush so the target is loaded.
- Counters, updated on the rising edge:
  - stall_cycles increments on every cycle with stall = 1.
  - flush_count increments on every cycle with IFID_Flush = 1.
  - Both saturate at 2^CNT_W - 1 and never wrap.
- Reset (reset = 0, asynchronous):
  - state = RUN, cnt = 0, stall_cycles = 0, flush_count = 0.
  - While reset is low, outputs are forced to PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0, IFID_Flush = 0.
  - Reset asserted in STALL abandons the remaining stall cycle.
- Register $0 never causes a hazard.
- A destination matching both Rs and Rt counts as one hazard, not two.
- Latency: stall takes effect in the same cycle as detection, with no added delay.

Test Plan:
- Load-use: IDEX_MemRead = 1, IDEX_WR = 8, IFID_Rs = 8, ID_Branch = 0 -> exactly 1 cycle of PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1; then stall_cycles = 1.
- Load then branch: ID_Branch = 1, IDEX_MemRead = 1, IDEX_WR = 9, IFID_Rt = 9, ID_UsesRt = 1 -> 2 consecutive stall cycles with state RUN->STALL->RUN; then ID_BranchTaken = 1 -> 1 cycle of IFID_Flush = 1; stall_cycles = 2, flush_count = 1.
- ALU then branch: IDEX_RegWrite = 1, IDEX_MemRead = 0, IDEX_WR = 10, IFID_Rs = 10, ID_Branch = 1 -> 1 stall cycle. Same case with IDEX_WR = 0 -> no stall.
- Stall with taken branch: BA hazard together with ID_BranchTaken = 1 -> IFID_Flush = 0 during the stall; IFID_Flush = 1 only on the following non-stall cycle.
- Reset mid-stall: enter STALL via the BL2 case, drive reset low during the STALL cycle -> outputs immediately 1/1/0/0, counters 0; after release, state is RUN.
- Saturation: with CNT_W = 4, hold a load-use hazard for 20 detections -> stall_cycles stops at 15.
